// File: rtl/control.sv
// Main decode/control unit of the single-cycle RV32I core.
// Class flags in, datapath steering out; plus a sticky decode-error bit.
module control #(
  parameter bit CHECK_OPCODE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        is_alu_reg,
  input  logic        is_alu_imm,
  input  logic        is_branch,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic        is_lui,
  input  logic        is_auipc,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        is_system,
  output logic        mem_read,
  output logic        mem_write,
  output logic        alu_src,
  output logic        branch_sig,
  output logic        jump,
  output logic [1:0]  alu_op,
  output logic [2:0]  imm_sel,
  output logic [1:0]  wb_sel,
  output logic [1:0]  op1_sel,
  output logic        decode_err,
  output logic        err_sticky
);

  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_J    = 3'd5;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] OP1_RS1  = 2'd0;
  localparam logic [1:0] OP1_PC   = 2'd1;
  localparam logic [1:0] OP1_ZERO = 2'd2;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_FN  = 2'b10;

  localparam logic [6:0] OPC_ALU_REG = 7'b0110011;
  localparam logic [6:0] OPC_ALU_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  logic [9:0] flags;
  logic [3:0] nflags;
  logic [6:0] exp_opc;
  logic       opc_err;
  logic       unused_instr;

  assign flags = {is_system, is_alu_reg, is_alu_imm,
                  is_auipc, is_lui, is_jalr, is_jal,
                  is_branch, is_store, is_load};

  assign unused_instr = ^{instr[31:15], instr[11:7]};

  always_comb begin
    nflags = '0;
    for (int i = 0; i < 10; i++)
      nflags = nflags + {3'b000, flags[i]};
  end

  // Overlapping flags resolve by fixed priority, so a plain
  // priority chain is intended rather than a unique decode.
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    branch_sig = 1'b0;
    jump       = 1'b0;
    alu_op     = ALU_ADD;
    imm_sel    = IMM_NONE;
    wb_sel     = WB_ALU;
    op1_sel    = OP1_RS1;
    exp_opc    = OPC_SYSTEM;
    priority case (1'b1)
      is_load: begin
        exp_opc  = OPC_LOAD;
        mem_read = 1'b1;
        alu_src  = 1'b1;
        imm_sel  = IMM_I;
        wb_sel   = WB_MEM;
      end
      is_store: begin
        exp_opc   = OPC_STORE;
        mem_write = 1'b1;
        alu_src   = 1'b1;
        imm_sel   = IMM_S;
      end
      is_branch: begin
        exp_opc    = OPC_BRANCH;
        branch_sig = 1'b1;
        alu_op     = ALU_BR;
        imm_sel    = IMM_B;
      end
      is_jal: begin
        exp_opc = OPC_JAL;
        alu_src = 1'b1;
        jump    = 1'b1;
        imm_sel = IMM_J;
        wb_sel  = WB_PC4;
        op1_sel = OP1_PC;
      end
      is_jalr: begin
        exp_opc = OPC_JALR;
        alu_src = 1'b1;
        jump    = 1'b1;
        imm_sel = IMM_I;
        wb_sel  = WB_PC4;
      end
      is_lui: begin
        exp_opc = OPC_LUI;
        alu_src = 1'b1;
        imm_sel = IMM_U;
        op1_sel = OP1_ZERO;
      end
      is_auipc: begin
        exp_opc = OPC_AUIPC;
        alu_src = 1'b1;
        imm_sel = IMM_U;
        op1_sel = OP1_PC;
      end
      is_alu_imm: begin
        exp_opc = OPC_ALU_IMM;
        alu_src = 1'b1;
        imm_sel = IMM_I;
        alu_op  = (instr[14:12] == 3'b000) ? ALU_ADD : ALU_FN;
      end
      is_alu_reg: begin
        exp_opc = OPC_ALU_REG;
        alu_op  = ALU_FN;
      end
      is_system: begin
        exp_opc = OPC_SYSTEM;
      end
      default: begin
        exp_opc = OPC_SYSTEM;
      end
    endcase
  end

  assign opc_err    = CHECK_OPCODE && (instr[6:0] != exp_opc);
  assign decode_err = (nflags != 4'd1) || opc_err;

  always_ff @(posedge clk) begin
    if (rst)
      err_sticky <= 1'b0;
    else
      err_sticky <= err_sticky | decode_err;
  end

endmodule

// File: tb/tb_control.sv
// Bench for control: directed class checks, randomized flag/opcode
// mixes against a table-driven model, and sticky-error sequencing.
module tb_control;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        is_alu_reg, is_alu_imm, is_branch, is_jal, is_jalr;
  logic        is_lui, is_auipc, is_load, is_store, is_system;
  logic        mem_read, mem_write, alu_src, branch_sig, jump;
  logic [1:0]  alu_op;
  logic [2:0]  imm_sel;
  logic [1:0]  wb_sel;
  logic [1:0]  op1_sel;
  logic        decode_err;
  logic        err_sticky;

  int n_checks;
  int n_fail;
  logic exp_sticky;

  control dut (
    .clk(clk), .rst(rst), .instr(instr),
    .is_alu_reg(is_alu_reg), .is_alu_imm(is_alu_imm),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
    .is_lui(is_lui), .is_auipc(is_auipc), .is_load(is_load),
    .is_store(is_store), .is_system(is_system),
    .mem_read(mem_read), .mem_write(mem_write), .alu_src(alu_src),
    .branch_sig(branch_sig), .jump(jump), .alu_op(alu_op),
    .imm_sel(imm_sel), .wb_sel(wb_sel), .op1_sel(op1_sel),
    .decode_err(decode_err), .err_sticky(err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Class indices in priority order (0 = highest).
  localparam int C_LOAD = 0, C_STORE = 1, C_BRANCH = 2, C_JAL = 3;
  localparam int C_JALR = 4, C_LUI = 5, C_AUIPC = 6, C_AIMM = 7;
  localparam int C_AREG = 8, C_SYS = 9;

  logic [6:0] opc [10];
  initial begin
    opc[C_LOAD]   = 7'b0000011; opc[C_STORE] = 7'b0100011;
    opc[C_BRANCH] = 7'b1100011; opc[C_JAL]   = 7'b1101111;
    opc[C_JALR]   = 7'b1100111; opc[C_LUI]   = 7'b0110111;
    opc[C_AUIPC]  = 7'b0010111; opc[C_AIMM]  = 7'b0010011;
    opc[C_AREG]   = 7'b0110011; opc[C_SYS]   = 7'b1110011;
  end

  // Packed as mr,mw,as,br,j,alu[2],imm[3],wb[2],op1[2],err.
  logic [14:0] obs;
  assign obs = {mem_read, mem_write, alu_src, branch_sig, jump,
                alu_op, imm_sel, wb_sel, op1_sel, decode_err};

  function automatic logic [14:0] model(input logic [9:0] f,
                                        input logic [31:0] ins);
    int k;
    logic mr, mw, as_, br, j, err;
    logic [1:0] alu, wb, o1;
    logic [2:0] imm;
    k = -1;
    for (int i = 9; i >= 0; i--) if (f[i]) k = i;
    {mr, mw, as_, br, j} = 5'b0;
    alu = 0; imm = 0; wb = 0; o1 = 0;
    case (k)
      C_LOAD:   begin mr = 1; as_ = 1; imm = 1; wb = 1; end
      C_STORE:  begin mw = 1; as_ = 1; imm = 2; end
      C_BRANCH: begin br = 1; alu = 1; imm = 3; end
      C_JAL:    begin as_ = 1; j = 1; imm = 5; wb = 2; o1 = 1; end
      C_JALR:   begin as_ = 1; j = 1; imm = 1; wb = 2; end
      C_LUI:    begin as_ = 1; imm = 4; o1 = 2; end
      C_AUIPC:  begin as_ = 1; imm = 4; o1 = 1; end
      C_AIMM:   begin
        as_ = 1; imm = 1;
        alu = (ins[14:12] == 3'b000) ? 2'd0 : 2'd2;
      end
      C_AREG:   alu = 2;
      default:  ;
    endcase
    err = ($countones(f) != 1) ||
          (k >= 0 && ins[6:0] != opc[k]) ||
          (k < 0 && ins[6:0] != opc[C_SYS]);
    return {mr, mw, as_, br, j, alu, imm, wb, o1, err};
  endfunction

  logic [9:0] cur_f;

  task automatic drive(input logic [9:0] f, input logic [31:0] ins);
    cur_f = f;
    instr = ins;
    {is_system, is_alu_reg, is_alu_imm, is_auipc, is_lui,
     is_jalr, is_jal, is_branch, is_store, is_load} = f;
  endtask

  function automatic logic [9:0] one(input int c);
    logic [9:0] v;
    v = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    drive(one(C_JAL), 32'h0000006F);
    @(posedge clk); @(posedge clk); #1;
    n_checks++;
    if (err_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_sticky got=%b exp=0", err_sticky);
    end
    n_checks++;
    if (obs !== model(cur_f, instr)) begin
      n_fail++;
      $display("FAIL reset_comb got=%h exp=%h", obs, model(cur_f, instr));
    end
    rst = 1'b0;
    exp_sticky = 1'b0;
  endtask

  task automatic test_classes;
    logic [31:0] ins [14];
    int cls [14];
    logic [14:0] e;
    ins[0]  = 32'h00000033;                          cls[0]  = C_AREG;
    ins[1]  = 32'h00500093;                          cls[1]  = C_AIMM;
    ins[2]  = {12'h0ff, 5'd1, 3'b111, 5'd2, 7'h13}; cls[2]  = C_AIMM;
    ins[3]  = {12'h0ff, 5'd1, 3'b110, 5'd2, 7'h13}; cls[3]  = C_AIMM;
    ins[4]  = {12'h0ff, 5'd1, 3'b100, 5'd2, 7'h13}; cls[4]  = C_AIMM;
    ins[5]  = {12'h0ff, 5'd1, 3'b010, 5'd2, 7'h13}; cls[5]  = C_AIMM;
    ins[6]  = {12'h0ff, 5'd1, 3'b011, 5'd2, 7'h13}; cls[6]  = C_AIMM;
    ins[7]  = {12'h403, 5'd1, 3'b101, 5'd2, 7'h13}; cls[7]  = C_AIMM;
    ins[8]  = 32'h01022303;                          cls[8]  = C_LOAD;
    ins[9]  = 32'h00112023;                          cls[9]  = C_STORE;
    ins[10] = 32'h00000063;                          cls[10] = C_BRANCH;
    ins[11] = 32'h0000006F;                          cls[11] = C_JAL;
    ins[12] = 32'h123450B7;                          cls[12] = C_LUI;
    ins[13] = 32'h00000097;                          cls[13] = C_AUIPC;
    for (int i = 0; i < 14; i++) begin
      drive(one(cls[i]), ins[i]);
      #1;
      e = model(cur_f, instr);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL class_%0d got=%h exp=%h", i, obs, e);
      end
    end
    drive(one(C_JALR), 32'h00008067);
    #1;
    n_checks++;
    if (obs !== 15'b00101_00_001_10_00_0) begin
      n_fail++;
      $display("FAIL jalr got=%b exp=001010000110000", obs);
    end
    drive(one(C_ALU_ADDI_CHECK()), 32'h00500093);
    #1;
    n_checks++;
    if (alu_op !== 2'b00 || alu_src !== 1'b1) begin
      n_fail++;
      $display("FAIL addi alu_op=%b src=%b exp=00/1", alu_op, alu_src);
    end
  endtask

  function automatic int C_ALU_ADDI_CHECK();
    return C_AIMM;
  endfunction

  task automatic test_errors;
    drive('0, 32'h00000013);
    #1;
    n_checks++;
    if (obs !== 15'b0000_0000_0000_001) begin
      n_fail++;
      $display("FAIL no_flags got=%b exp=000000000000001", obs);
    end
    drive(one(C_LOAD) | one(C_STORE), 32'h00002003);
    #1;
    n_checks++;
    if (obs !== 15'b10100_00_001_01_00_1) begin
      n_fail++;
      $display("FAIL load_store got=%b exp=101000000101001", obs);
    end
    drive(one(C_LOAD), 32'h00000033);
    #1;
    n_checks++;
    if (decode_err !== 1'b1 || mem_read !== 1'b1) begin
      n_fail++;
      $display("FAIL load_bad_opc err=%b mr=%b exp=1/1",
               decode_err, mem_read);
    end
    drive(one(C_SYS), 32'h00000073);
    #1;
    n_checks++;
    if (obs !== 15'b0) begin
      n_fail++;
      $display("FAIL system got=%b exp=0", obs);
    end
  endtask

  task automatic test_sticky;
    rst = 1'b1;
    drive(one(C_AREG), 32'h00000033);
    @(posedge clk); #1;
    n_checks++;
    if (err_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL sticky_rst got=%b exp=0", err_sticky);
    end
    rst = 1'b0;
    drive('0, 32'h0);
    @(posedge clk); #1;
    n_checks++;
    if (err_sticky !== 1'b1) begin
      n_fail++;
      $display("FAIL sticky_set got=%b exp=1", err_sticky);
    end
    drive(one(C_AREG), 32'h00000033);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (err_sticky !== 1'b1) begin
      n_fail++;
      $display("FAIL sticky_hold got=%b exp=1", err_sticky);
    end
    rst = 1'b1;
    drive(one(C_LOAD) | one(C_JAL), 32'h0);
    @(posedge clk); #1;
    n_checks++;
    if (err_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL sticky_rst_prio got=%b exp=0", err_sticky);
    end
    rst = 1'b0;
    drive(one(C_AREG), 32'h00000033);
    @(posedge clk); #1;
    n_checks++;
    if (err_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL sticky_clean got=%b exp=0", err_sticky);
    end
    exp_sticky = 1'b0;
  endtask

  task automatic test_random;
    logic [9:0] f;
    logic [31:0] ins;
    logic [14:0] e;
    int mode, c;
    for (int n = 0; n < 300; n++) begin
      mode = int'($urandom_range(0, 9));
      ins = $urandom;
      c = int'($urandom_range(0, 9));
      f = one(c);
      if (mode < 6) ins[6:0] = opc[c];
      else if (mode < 8) f = 10'($urandom);
      if (mode == 5) ins[14:12] = 3'b000;
      rst = ($urandom_range(0, 19) == 0);
      drive(f, ins);
      #1;
      e = model(cur_f, instr);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL rand_comb_%0d f=%b ins=%h got=%h exp=%h",
                 n, f, ins, obs, e);
      end
      exp_sticky = rst ? 1'b0 : (exp_sticky | e[0]);
      @(posedge clk); #1;
      n_checks++;
      if (err_sticky !== exp_sticky) begin
        n_fail++;
        $display("FAIL rand_sticky_%0d got=%b exp=%b",
                 n, err_sticky, exp_sticky);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    exp_sticky = 1'b0;
    rst = 1'b1;
    drive('0, 32'h0);
    test_reset;
    test_classes;
    test_errors;
    test_sticky;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control.md
Name: control

Overview:
- Main decode/control unit of the single-cycle RV32I core.
- Sits between the instruction decoder and the datapath. The decoder supplies one-hot instruction-class flags plus the raw instruction word.
- Drives the datapath steering signals combinationally: memory enables, ALU source/op class, immediate format, writeback select, operand-1 select, branch/jump.
- Also flags malformed decode and keeps a sticky, clocked error bit for debug.

Parameters:
- CHECK_OPCODE, 1, when 1 the flags are cross-checked against instr[6:0]. A mismatch contributes to decode_err.

Ports:
- clk  in  1  system clock (used only by err_sticky)
- rst  in  1  synchronous active-high reset
- instr  in  32  current instruction word
- is_alu_reg, is_alu_imm, is_branch, is_jal, is_jalr, is_lui, is_auipc, is_load, is_store, is_system  in  1 each  one-hot class flags
- mem_read  out  1  data-memory read enable
- mem_write  out  1  data-memory write enable
- alu_src  out  1  ALU operand 2: 0=rs2, 1=immediate
- branch_sig  out  1  conditional branch instruction
- jump  out  1  unconditional jump (JAL/JALR)
- alu_op  out  2  00=add, 01=branch compare (sub), 10=decode by funct3/funct7
- imm_sel  out  3  Imm_NONE=0, Imm_I=1, Imm_S=2, Imm_B=3, Imm_U=4, Imm_J=5 (defines.vh)
- wb_sel  out  2  WB_ALU=0, WB_MEM=1, WB_PC4=2 (defines.vh)
- op1_sel  out  2  OP1_RS1=0, OP1_PC=1, OP1_ZERO=2
- decode_err  out  1  combinational malformed-decode indication
- err_sticky  out  1  registered, sticky decode error

Behaviour:
- All control outputs except err_sticky are purely combinational from the inputs, with zero latency. They must settle within the same cycle and are independent of clk/rst.
- Defaults (no flag, or is_system alone): all single-bit outputs 0, alu_op=00, imm_sel=Imm_NONE, wb_sel=WB_ALU, op1_sel=OP1_RS1.
- Required values per class, listed as mr/mw/as/br/j/alu/imm/wb/op1:
  - alu_reg: 0/0/0/0/0/10/NONE/ALU/RS1
  - alu_imm: 0/0/1/0/0/X/I/ALU/RS1. X=00 when funct3 (instr[14:12])=000 (ADDI), otherwise 10. This covers SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI.
  - load: 1/0/1/0/0/00/I/MEM/RS1
  - store: 0/1/1/0/0/00/S/ALU/RS1
  - branch: 0/0/0/1/0/01/B/ALU/RS1
  - jal: 0/0/1/0/1/00/J/PC4/PC
  - jalr: 0/0/1/0/1/00/I/PC4/RS1
  - lui: 0/0/1/0/0/00/U/ALU/ZERO
  - auipc: 0/0/1/0/0/00/U/ALU/PC
  - system: defaults; no memory or jump side effects.
- Multiple flags asserted: outputs follow fixed priority load > store > branch > jal > jalr > lui > auipc > alu_imm > alu_reg > system. decode_err=1.
- decode_err=1 when either of the following holds:
  - the number of asserted flags is not exactly 1;
  - CHECK_OPCODE=1 and instr[6:0] ≠ the opcode of the asserted flag. Opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 1110011.
- err_sticky:
  - on posedge clk, when rst=1 it is cleared to 0;
  - else it becomes err_sticky | decode_err;
  - once set, it holds until reset;
  - rst has priority over a simultaneous decode_err.
- Reset has no effect on the combinational outputs.

Test Plan:
- R-type: is_alu_reg=1, instr=0x00000033 -> alu_op=10, imm=NONE, wb=ALU, op1=RS1, alu_src=0, decode_err=0.
- ALU-imm sweep: ADDI (funct3=000) -> alu_op=00. ANDI/ORI/XORI/SLTI/SLTIU/SLLI/SRLI/SRAI (imm 0x403 for SRAI) -> alu_op=10. All with alu_src=1, imm=I, wb=ALU, op1=RS1.
- Memory and branch:
  - LW (0x01022303 shape) -> mem_read=1, alu_src=1, imm=I, wb=MEM.
  - SW -> mem_write=1, imm=S, wb=ALU.
  - BEQ -> branch_sig=1, alu_op=01, imm=B, alu_src=0.
- Jumps and upper immediates:
  - JAL -> jump=1, imm=J, wb=PC4, op1=PC.
  - JALR -> jump=1, imm=I, wb=PC4, op1=RS1.
  - LUI 0x12345 -> imm=U, op1=ZERO, alu_src=1.
  - AUIPC -> imm=U, op1=PC.
- Errors:
  - no flags -> defaults, decode_err=1.
  - is_load+is_store -> load outputs, decode_err=1.
  - is_load with instr[6:0]=0110011 -> decode_err=1.
- Sticky error:
  - rst=1 one cycle -> err_sticky=0.
  - one-cycle decode_err pulse -> err_sticky=1 next edge and held after valid decodes.
  - rst=1 concurrent with decode_err -> 0.
